// File: rtl/gpio_pkg.sv
// Shared definitions for the gpio block and its pin conditioner: widths,
// register offsets inside a 4-register window, and default base addresses.
package gpio_pkg;

    localparam int GPIO_WIDTH = 8;

    localparam logic [1:0] STATE_OFS   = 2'd0;
    localparam logic [1:0] RISE_EN_OFS = 2'd1;
    localparam logic [1:0] FALL_EN_OFS = 2'd2;
    localparam logic [1:0] FLAGS_OFS   = 2'd3;

    localparam logic [7:0] GPIO_BASE_ADDRESS          = 8'h00;
    localparam logic [7:0] GPIO_PIN_COND_BASE_ADDRESS = 8'h04;

    // True when addr falls in the 4-register window starting at base.
    function automatic logic in_window(input logic [7:0] addr, input logic [7:0] base);
        logic [7:0] ofs;
        ofs = addr - base;
        return (ofs[7:2] == 6'd0);
    endfunction

endpackage

// File: rtl/gpio_pin_conditioner_pin_debounce.sv
// One pad input: two-flop synchroniser, stability counter and clean level.
// clean_nxt exposes the value clean takes at the next edge for edge detection.
module pin_debounce #(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic clean,
    output logic clean_nxt
);

    logic        s1_q, s1_d;
    logic        s2_q, s2_d;
    logic        clean_q, clean_d;
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        s1_d    = raw;
        s2_d    = s1_q;
        cnt_d   = cnt_q;
        clean_d = clean_q;
        if (s2_q == clean_q) begin
            cnt_d = 16'd0;
        end else if (cnt_q == DEBOUNCE_CYCLES - 16'd1) begin
            clean_d = s2_q;
            cnt_d   = 16'd0;
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            cnt_q   <= 16'd0;
            clean_q <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
        end
    end

    assign clean     = clean_q;
    assign clean_nxt = clean_d;

endmodule

// File: rtl/gpio_pin_conditioner.sv
// Pad input conditioner: per-pin synchronise/debounce, edge flags with
// per-bit enables, level interrupt and a 4-register IO bus window.
module gpio_pin_conditioner
    import gpio_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDRESS    = GPIO_PIN_COND_BASE_ADDRESS,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [GPIO_WIDTH-1:0] pins_raw,
    input  logic [7:0]            din,
    input  logic [7:0]            address,
    input  logic                  w_en,
    input  logic                  r_en,
    output logic [7:0]            dout,
    output logic [GPIO_WIDTH-1:0] pins_clean,
    output logic                  irq
);

    logic [GPIO_WIDTH-1:0] clean, clean_nxt;
    logic [GPIO_WIDTH-1:0] rise, fall;
    logic [GPIO_WIDTH-1:0] rise_en_q, rise_en_d;
    logic [GPIO_WIDTH-1:0] fall_en_q, fall_en_d;
    logic [GPIO_WIDTH-1:0] flags_q, flags_d;
    logic [7:0]            dout_q, dout_d;
    logic [7:0]            ofs;
    logic                  hit;
    logic [7:0]            rd_data;
    logic [GPIO_WIDTH-1:0] clr;

    for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_pin
        pin_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk      (clk),
            .rst_n    (rst_n),
            .raw      (pins_raw[i]),
            .clean    (clean[i]),
            .clean_nxt(clean_nxt[i])
        );
    end

    // Edges are taken against the next clean value so flags set on the same
    // edge that pins_clean changes.
    assign rise = clean_nxt & ~clean;
    assign fall = ~clean_nxt & clean;

    assign ofs = address - BASE_ADDRESS;
    assign hit = in_window(address, BASE_ADDRESS);

    always_comb begin
        rd_data = 8'h00;
        case (ofs[1:0])
            STATE_OFS:   rd_data = clean;
            RISE_EN_OFS: rd_data = rise_en_q;
            FALL_EN_OFS: rd_data = fall_en_q;
            FLAGS_OFS:   rd_data = flags_q;
            default:     rd_data = 8'h00;
        endcase
    end

    always_comb begin
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        clr       = '0;
        dout_d    = dout_q;
        if (w_en && hit) begin
            case (ofs[1:0])
                RISE_EN_OFS: rise_en_d = din;
                FALL_EN_OFS: fall_en_d = din;
                FLAGS_OFS:   clr       = din;
                default:     ;
            endcase
        end
        if (r_en && hit) begin
            dout_d = rd_data;
        end
        // A set on the same edge as a clear keeps the flag.
        flags_d = (flags_q & ~clr) | (rise & rise_en_q) | (fall & fall_en_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rise_en_q <= '0;
            fall_en_q <= '0;
            flags_q   <= '0;
            dout_q    <= 8'h00;
        end else begin
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            flags_q   <= flags_d;
            dout_q    <= dout_d;
        end
    end

    assign dout       = dout_q;
    assign pins_clean = clean;
    assign irq        = |flags_q;

endmodule

// File: tb/tb_gpio_pin_conditioner.sv
// Directed bench: register-map vectors from a table, then hand-written
// debounce, glitch, flag, set/clear collision and mid-debounce reset cases.
module tb_gpio_pin_conditioner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rst_n_l = 1'b0;
    logic [7:0] pins_raw = 8'h00;
    logic [7:0] pins_raw_l = 8'h00;
    logic [7:0] din = 8'h00;
    logic [7:0] address = 8'h00;
    logic       w_en = 1'b0;
    logic       r_en = 1'b0;
    logic [7:0] dout, dout_l;
    logic [7:0] pins_clean, pins_clean_l;
    logic       irq, irq_l;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gpio_pin_conditioner #(.BASE_ADDRESS(8'h04), .DEBOUNCE_CYCLES(16'd4)) dut (
        .clk(clk), .rst_n(rst_n), .pins_raw(pins_raw), .din(din), .address(address),
        .w_en(w_en), .r_en(r_en), .dout(dout), .pins_clean(pins_clean), .irq(irq)
    );

    gpio_pin_conditioner #(.BASE_ADDRESS(8'h04), .DEBOUNCE_CYCLES(16'd1000)) dut_long (
        .clk(clk), .rst_n(rst_n_l), .pins_raw(pins_raw_l), .din(din), .address(address),
        .w_en(w_en), .r_en(r_en), .dout(dout_l), .pins_clean(pins_clean_l), .irq(irq_l)
    );

    typedef struct {
        logic       wr;
        logic       rd;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp_dout;
    } vec_t;

    vec_t tbl[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
        address = a; din = d; w_en = 1'b1;
        tick();
        w_en = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
        address = a; r_en = 1'b1;
        tick();
        r_en = 1'b0;
        d = dout;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [7:0] rd;
        int n;

        tbl[0]  = '{1'b0, 1'b1, 8'h04, 8'h00, 8'h00};
        tbl[1]  = '{1'b0, 1'b1, 8'h05, 8'h00, 8'h00};
        tbl[2]  = '{1'b0, 1'b1, 8'h06, 8'h00, 8'h00};
        tbl[3]  = '{1'b0, 1'b1, 8'h07, 8'h00, 8'h00};
        tbl[4]  = '{1'b1, 1'b0, 8'h05, 8'hA5, 8'h00};
        tbl[5]  = '{1'b1, 1'b0, 8'h06, 8'h3C, 8'h00};
        tbl[6]  = '{1'b0, 1'b1, 8'h05, 8'h00, 8'hA5};
        tbl[7]  = '{1'b0, 1'b1, 8'h06, 8'h00, 8'h3C};
        tbl[8]  = '{1'b1, 1'b0, 8'h04, 8'hFF, 8'h3C};
        tbl[9]  = '{1'b0, 1'b1, 8'h04, 8'h00, 8'h00};
        tbl[10] = '{1'b0, 1'b1, 8'h06, 8'h00, 8'h3C};
        tbl[11] = '{1'b1, 1'b0, 8'h09, 8'h55, 8'h3C};
        tbl[12] = '{1'b0, 1'b1, 8'h09, 8'h00, 8'h3C};
        tbl[13] = '{1'b0, 1'b1, 8'h05, 8'h00, 8'hA5};
        tbl[14] = '{1'b0, 1'b1, 8'h03, 8'h00, 8'hA5};
        tbl[15] = '{1'b0, 1'b1, 8'h07, 8'h00, 8'h00};
        tbl[16] = '{1'b1, 1'b0, 8'h05, 8'h00, 8'h00};
        tbl[17] = '{1'b1, 1'b0, 8'h06, 8'h00, 8'h00};
        tbl[18] = '{1'b0, 1'b1, 8'h06, 8'h00, 8'h00};

        ticks(3);
        chk("reset_dout", dout, 8'h00);
        chk("reset_irq", irq, 1'b0);
        chk("reset_pins_clean", pins_clean, 8'h00);
        rst_n = 1'b1;
        ticks(2);

        for (int i = 0; i < 19; i++) begin
            address = tbl[i].addr;
            din     = tbl[i].data;
            w_en    = tbl[i].wr;
            r_en    = tbl[i].rd;
            tick();
            w_en = 1'b0;
            r_en = 1'b0;
            chk($sformatf("vec%0d_dout", i), dout, tbl[i].exp_dout);
            chk($sformatf("vec%0d_irq", i), irq, 1'b0);
        end

        // Debounce latency: raw first sampled at edge k, clean at edge k+5.
        pins_raw = 8'h01;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (pins_clean == 8'h01) begin
                n = i;
                break;
            end
        end
        chk("latency_ticks", n, 6);
        bus_read(8'h07, rd);
        chk("latency_no_flag", rd, 8'h00);

        // 3-cycle glitch on pin 2 with its rise enabled.
        bus_write(8'h05, 8'h04);
        pins_raw = 8'h05;
        ticks(3);
        pins_raw = 8'h01;
        ticks(10);
        chk("glitch_pins_clean", pins_clean, 8'h01);
        bus_read(8'h07, rd);
        chk("glitch_flags", rd, 8'h00);

        // Rise on pin 0 and fall on pin 7.
        bus_write(8'h05, 8'h00);
        pins_raw = 8'h80;
        ticks(10);
        chk("pre_edge_clean", pins_clean, 8'h80);
        bus_write(8'h05, 8'h01);
        bus_write(8'h06, 8'h80);
        chk("enable_not_retro_irq", irq, 1'b0);
        pins_raw = 8'h01;
        ticks(10);
        chk("edge_irq", irq, 1'b1);
        bus_read(8'h07, rd);
        chk("edge_flags", rd, 8'h81);
        bus_write(8'h07, 8'h01);
        bus_read(8'h07, rd);
        chk("clr0_flags", rd, 8'h80);
        chk("clr0_irq", irq, 1'b1);
        bus_write(8'h07, 8'h80);
        chk("clr7_irq_next_cycle", irq, 1'b0);
        bus_read(8'h07, rd);
        chk("clr7_flags", rd, 8'h00);

        // Clear write landing on the same edge as pin 0's rise flag.
        pins_raw = 8'h00;
        ticks(10);
        chk("fall0_no_flag_irq", irq, 1'b0);
        pins_raw = 8'h01;
        ticks(5);
        chk("collide_before_irq", irq, 1'b0);
        bus_write(8'h07, 8'h01);
        chk("collide_clean", pins_clean, 8'h01);
        chk("collide_irq", irq, 1'b1);
        bus_read(8'h07, rd);
        chk("collide_flags", rd, 8'h01);

        // Mid-debounce reset on the 1000-cycle instance, pin 3.
        rst_n_l = 1'b1;
        ticks(2);
        pins_raw_l = 8'h08;
        ticks(500);
        chk("long_mid_clean", pins_clean_l, 8'h00);
        rst_n_l = 1'b0;
        tick();
        chk("long_in_reset_clean", pins_clean_l, 8'h00);
        rst_n_l = 1'b1;
        n = 0;
        for (int i = 1; i <= 1100; i++) begin
            tick();
            if (pins_clean_l[3]) begin
                n = i;
                break;
            end
        end
        chk("long_release_ticks", n, 1002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
